// File: rtl/maquina_evt_scheduler.sv
// Panel-input scheduler for the vending machine: sync, optional debounce (MAQUINA_DEBOUNCE_EN),
// edge capture into pending flags, and fixed-priority valid/ready issue to the machine core.
module maquina_evt_scheduler #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       busy,
    output logic [3:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_range
        $error("DEB_CYCLES must lie in 2..255");
    end

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] deb_lvl;
    logic [3:0] deb_prev_q;
    logic [3:0] pend_q, pend_d;
    logic [3:0] drop_q, drop_d;
    logic [3:0] rise, served, drops;
    state_t     state_q, state_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;

    // Event code to panel bit {P,R,N,D}: 0=N, 1=D, 2=P, 3=R.
    function automatic logic [3:0] code_mask(input logic [1:0] code);
        case (code)
            2'd0:    code_mask = 4'b0010;
            2'd1:    code_mask = 4'b0001;
            2'd2:    code_mask = 4'b1000;
            default: code_mask = 4'b0100;
        endcase
    endfunction

    // R > D > N > P: coins are credited before a purchase, refund overrides all.
    function automatic logic [1:0] pick(input logic [3:0] p);
        if (p[2])      pick = 2'd3;
        else if (p[0]) pick = 2'd1;
        else if (p[1]) pick = 2'd0;
        else           pick = 2'd2;
    endfunction

`ifdef MAQUINA_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    deb_q, deb_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
                else                                 cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // NOTE: the counters are plain flops, so they share the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = sync2_q;
`endif

    always_comb begin
        rise   = deb_lvl & ~deb_prev_q;
        served = (state_q == ISSUE && evt_ready) ? code_mask(code_q) : 4'b0000;
        // A new edge on the bit being served wins and is not a drop.
        pend_d = rise | (pend_q & ~served);
        drops  = rise & pend_q & ~served;
        drop_d = drop_q;
        for (int i = 0; i < 4; i++) begin
            if (drops[i] && drop_d != 4'hF) drop_d = drop_d + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_prev_q <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
        end else begin
            sync1_q    <= sw_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_lvl;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    code_d  = pick(pend_q);
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign busy      = |pend_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_maquina_evt_scheduler.sv
// Directed bench for maquina_evt_scheduler (DEB_CYCLES = 4); adapts latency to MAQUINA_DEBOUNCE_EN.
module tb_maquina_evt_scheduler;

`ifdef MAQUINA_DEBOUNCE_EN
    localparam int L = 4;
`else
    localparam int L = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw_raw = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       busy;
    logic [3:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] sw;
        logic       ready;
        logic       valid;
        logic [1:0] code;
        logic       busy;
        logic [3:0] drop;
    } vec_t;

    vec_t vecs[$];

    maquina_evt_scheduler #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw_raw    = 4'b0000;
        evt_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] m);
        sw_raw = m;
        repeat (L + 3) step();
        sw_raw = 4'b0000;
        repeat (L + 3) step();
    endtask

    function automatic void add(input logic [3:0] sw, input logic rdy, input logic v,
                                input logic [1:0] c, input logic b, input logic [3:0] d);
        vecs.push_back('{sw, rdy, v, c, b, d});
    endfunction

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            sw_raw    = vecs[i].sw;
            evt_ready = vecs[i].ready;
            step();
            check($sformatf("%s[%0d].valid", tag, i), evt_valid, vecs[i].valid);
            check($sformatf("%s[%0d].busy", tag, i), busy, vecs[i].busy);
            check($sformatf("%s[%0d].drop", tag, i), drop_cnt, vecs[i].drop);
            if (vecs[i].valid) check($sformatf("%s[%0d].code", tag, i), evt_code, vecs[i].code);
        end
        vecs.delete();
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", evt_valid, 0);
        check("rst.code", evt_code, 0);
        check("rst.busy", busy, 0);
        check("rst.drop", drop_cnt, 0);

        // Single N press, ready tied high: one-cycle event after edge L+3.
        do_reset();
        for (int e = 0; e <= L + 7; e++)
            add(4'b0010, 1'b1, e == L + 3, 2'd0, (e == L + 2) || (e == L + 3), 4'd0);
        run_table("single");

        // All four rise together: R, D, N, P spaced 3 cycles apart.
        do_reset();
        for (int e = 0; e <= L + 16; e++) begin
            logic [1:0] c;
            c = (e == L + 3) ? 2'd3 : (e == L + 6) ? 2'd1 : (e == L + 9) ? 2'd0 : 2'd2;
            add(4'hF, 1'b1, (e == L + 3) || (e == L + 6) || (e == L + 9) || (e == L + 12), c,
                (e >= L + 2) && (e <= L + 12), 4'd0);
        end
        run_table("simul");

        // Backpressure on D with a mid-stall R press.
        do_reset();
        sw_raw = 4'b0001;
        repeat (L + 4) step();
        check("bp.start.valid", evt_valid, 1);
        check("bp.start.code", evt_code, 1);
        sw_raw = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) sw_raw = 4'b0100;
            step();
            check($sformatf("bp.stall[%0d].valid", c), evt_valid, 1);
            check($sformatf("bp.stall[%0d].code", c), evt_code, 1);
        end
        evt_ready = 1'b1;
        step();
        check("bp.k.valid", evt_valid, 0);
        check("bp.k.busy", busy, 1);
        step();
        check("bp.k1.valid", evt_valid, 0);
        step();
        check("bp.k2.valid", evt_valid, 1);
        check("bp.k2.code", evt_code, 3);
        step();
        check("bp.k3.valid", evt_valid, 0);
        check("bp.k3.busy", busy, 0);

        // New D edge lands on the same edge that serves D: flag survives, no drop.
        do_reset();
        sw_raw = 4'b0001;
        repeat (L + 4) step();
        check("win.first.valid", evt_valid, 1);
        sw_raw = 4'b0000;
        repeat (L + 3) step();
        sw_raw = 4'b0001;
        repeat (L + 2) step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("win.k.valid", evt_valid, 0);
        check("win.k.busy", busy, 1);
        check("win.k.drop", drop_cnt, 0);
        step();
        check("win.k1.valid", evt_valid, 0);
        step();
        check("win.k2.valid", evt_valid, 1);
        check("win.k2.code", evt_code, 1);

        // Repeated D presses while stalled: drops count and saturate.
        do_reset();
        for (int p = 1; p <= 20; p++) begin
            press(4'b0001);
            if (p == 3) begin
                check("drop3.cnt", drop_cnt, 2);
                check("drop3.valid", evt_valid, 1);
                check("drop3.code", evt_code, 1);
            end
            if (p == 10) check("drop10.cnt", drop_cnt, 9);
            if (p == 15) check("drop15.cnt", drop_cnt, 14);
            if (p == 16) check("drop16.cnt", drop_cnt, 15);
            if (p == 20) check("drop20.cnt", drop_cnt, 15);
        end

        // Bounce on N.
        do_reset();
        evt_ready = 1'b1;
`ifdef MAQUINA_DEBOUNCE_EN
        for (int g = 1; g <= 3; g++) begin
            sw_raw = 4'b0010;
            repeat (g) step();
            sw_raw = 4'b0000;
            for (int c = 0; c < L + 6; c++) begin
                step();
                check($sformatf("glitch%0d[%0d].valid", g, c), evt_valid, 0);
                check($sformatf("glitch%0d[%0d].busy", g, c), busy, 0);
            end
        end
`else
        sw_raw = 4'b0010;
        step();
        sw_raw = 4'b0000;
        step();
        step();
        check("glitch.e2.busy", busy, 1);
        check("glitch.e2.valid", evt_valid, 0);
        step();
        check("glitch.e3.valid", evt_valid, 1);
        check("glitch.e3.code", evt_code, 0);
`endif

        // Async reset during ISSUE with P held through release.
        do_reset();
        sw_raw = 4'b1000;
        repeat (L + 4) step();
        check("arst.pre.valid", evt_valid, 1);
        check("arst.pre.code", evt_code, 2);
        #2;
        reset = 1'b1;
        #1;
        check("arst.valid", evt_valid, 0);
        check("arst.code", evt_code, 0);
        check("arst.busy", busy, 0);
        check("arst.drop", drop_cnt, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int e = 0; e <= L + 3; e++) begin
            step();
            check($sformatf("arst.post[%0d].valid", e), evt_valid, e == L + 3);
        end
        check("arst.post.code", evt_code, 2);
        evt_ready = 1'b1;
        for (int c = 0; c < 2 * L + 8; c++) begin
            step();
            check($sformatf("arst.once[%0d].valid", c), evt_valid, 0);
            check($sformatf("arst.once[%0d].busy", c), busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maquina_evt_scheduler.md
# maquina_evt_scheduler

Input-side controller for the vending machine FSM. Synchronizes and optionally debounces the four front-panel lines, detects presses, and queues them as pending requests. It then issues them one at a time, in fixed priority, to the machine core over a valid/ready handshake. Simultaneous presses are never lost, and presses that arrive while the same request is still pending are counted.

## Interface
Parameters:
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a level change (range 2..255). Only used when debouncing is compiled in.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `sw_raw` in 4: asynchronous panel lines `{P,R,N,D}`.
  - bit3 P = purchase request
  - bit2 R = refund request
  - bit1 N = nickel inserted
  - bit0 D = dime inserted
- `evt_valid` out 1: event offered to the machine core.
- `evt_code` out 2: event identity. 0 = N, 1 = D, 2 = P, 3 = R.
- `evt_ready` in 1: core accepts the event.
- `busy` out 1: OR of the four pending flags.
- `drop_cnt` out 4: saturating count of presses dropped because the same request was already pending.

## Operation
Input path (per bit):
- 2-flop synchronizer, reset to 0.
- Debouncer (see Configuration), reset to 0.
- Rising-edge detect on the debounced level sets `pend[i]`.
- Falling edges are ignored.
- An input held high through reset deassertion yields exactly one event.

Pending flags:
- A rising edge while `pend[i]` = 1 leaves the flag set and increments `drop_cnt` (holds at 15).
- If a new edge and the handshake clearing the same bit occur in the same cycle, the edge wins. `pend[i]` stays 1, and this is not counted as a drop.

Arbiter FSM, states IDLE, ISSUE, GAP:
- IDLE: if `busy`, latch `evt_code` = highest-priority pending bit, assert `evt_valid`, and go to ISSUE. Priority is R > D > N > P, so coins are credited before a purchase is evaluated and refund overrides all.
- ISSUE: `evt_valid` = 1 and `evt_code` is held stable until `evt_ready` is sampled 1.
  - On that edge: clear the served `pend` bit, deassert `evt_valid`, go to GAP.
  - New pends arriving meanwhile do not change `evt_code`.
- GAP: one idle cycle, then IDLE.
- `evt_ready` is ignored outside ISSUE.

## Timing
- Reset values: `evt_valid` = 0, `evt_code` = 0, `busy` = 0, `drop_cnt` = 0, FSM = IDLE, all sync/debounce/pend state = 0.
- Reset asserted mid-ISSUE drops `evt_valid` immediately (asynchronous). The in-flight event is lost.
- Edge numbering: `sw_raw` rising is first sampled at edge 0.
- Without debounce:
  - `pend` set after edge 2; `busy` = 1 in the following cycle.
  - `evt_valid` = 1 after edge 3.
- With debounce: add `DEB_CYCLES` edges to both figures.
- Handshake: event accepted at edge k (`evt_valid` & `evt_ready`).
  - `evt_valid` = 0 after edge k and after edge k+1.
  - Next event may assert after edge k+2.
  - Peak throughput: 1 event / 3 cycles with `evt_ready` tied high.
- All outputs are registered. No combinational path from `evt_ready` to any output.

## Configuration
- `MAQUINA_DEBOUNCE_EN` defined:
  - Per-bit counter, width of `DEB_CYCLES`.
  - Counter increments while the synced level differs from the debounced level and resets to 0 when they match.
  - On reaching `DEB_CYCLES` the debounced level flips and the counter resets.
- `MAQUINA_DEBOUNCE_EN` undefined:
  - Debounced level = synchronizer output. No counters are synthesized.
  - `DEB_CYCLES` is ignored.

## Test plan
Benches use `DEB_CYCLES` = 4 with the macro defined unless noted.
- Single press: N high at edge 0, `evt_ready` = 1.
  - `evt_valid` = 1 with `evt_code` = 0 after edge 7, for exactly one cycle.
  - `busy` returns to 0.
- Simultaneous press: P, R, N, D all rise together, `evt_ready` = 1.
  - Codes issued in order 3, 1, 0, 2, spaced 3 cycles apart.
  - `drop_cnt` = 0.
- Backpressure: D pending, `evt_ready` = 0 for 10 cycles.
  - `evt_valid` stays 1 and `evt_code` stays 1 throughout.
  - A mid-stall R press does not change `evt_code`; R is issued next after GAP.
- Drops: D pressed 3 times while `evt_ready` = 0. `drop_cnt` = 2. After 20 such presses, `drop_cnt` = 15 (saturated).
- Bounce:
  - Glitches of 1–3 cycles on N: no event.
  - With the macro undefined: a 1-cycle glitch yields an event after edge 3.
- Reset: assert `reset` asynchronously during ISSUE.
  - All outputs 0 immediately.
  - With P held high through release: exactly one P event (`evt_code` = 2).
